// File: rtl/pipe_pkg.sv
// Shared constants and types for the elastic pipeline-stage buffer.
`default_nettype none

package pipe_pkg;

  localparam logic [31:0]  NOP_INSTR      = 32'h00000013;
  localparam logic [127:0] DEFAULT_BUBBLE = {96'b0, NOP_INSTR};

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = EMPTY,
    ST_ONE   = ONE,
    ST_FULL  = FULL
  } occ_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_entry.sv
// One payload slot: loadable data register plus valid bit, cleared to RST_VAL.
`default_nettype none

module pipe_entry #(
  parameter int               WIDTH   = 128,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             v_in,
  output logic [WIDTH-1:0] q,
  output logic             v
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= RST_VAL;
      v <= 1'b0;
    end else if (load) begin
      q <= d;
      v <= v_in;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: valid/ready handshake, optional skid slot,
// flush to bubble and a saturating stall-cycle counter.
`default_nettype none

module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 128,
  parameter int               SKID        = 1,
  parameter logic [WIDTH-1:0] BUBBLE_VAL  = WIDTH'(DEFAULT_BUBBLE),
  parameter int               STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [WIDTH-1:0]       i_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH-1:0]       o_data,
  input  logic                   i_flush,
  output logic [1:0]             o_count,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  occ_state_e state, state_nxt;

  logic             push, pop;
  logic             main_load, main_v_in, main_valid;
  logic [WIDTH-1:0] main_d;
  logic             skid_load, skid_v_in, skid_valid;
  logic [WIDTH-1:0] skid_d, skid_q;
  logic [STALL_CNT_W-1:0] stall_cnt;

  assign push = i_valid && o_ready;
  assign pop  = o_valid && i_ready;

  pipe_entry #(.WIDTH(WIDTH), .RST_VAL(BUBBLE_VAL)) u_main (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (i_flush),
    .load  (main_load),
    .d     (main_d),
    .v_in  (main_v_in),
    .q     (o_data),
    .v     (main_valid)
  );

  // With SKID=0 the FSM never reaches FULL, so this slot is never loaded.
  pipe_entry #(.WIDTH(WIDTH), .RST_VAL(BUBBLE_VAL)) u_skid (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (i_flush),
    .load  (skid_load),
    .d     (skid_d),
    .v_in  (skid_v_in),
    .q     (skid_q),
    .v     (skid_valid)
  );

  assign o_valid = main_valid;
  assign o_count = state;

  generate
    if (SKID != 0) begin : g_skid
      assign o_ready = !skid_valid;
    end else begin : g_no_skid
      assign o_ready = !main_valid || i_ready;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
    main_d    = i_data;
    main_v_in = 1'b1;
    skid_load = 1'b0;
    skid_d    = i_data;
    skid_v_in = 1'b1;
    case (state)
      ST_EMPTY: begin
        if (push) begin
          main_load = 1'b1;
          state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_load = 1'b1;
        end else if (pop) begin
          main_load = 1'b1;
          main_d    = BUBBLE_VAL;
          main_v_in = 1'b0;
          state_nxt = ST_EMPTY;
        end else if (push && (SKID != 0)) begin
          skid_load = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        // o_ready is low here, so only a pop can occur.
        if (pop) begin
          main_load = 1'b1;
          main_d    = skid_q;
          skid_load = 1'b1;
          skid_d    = BUBBLE_VAL;
          skid_v_in = 1'b0;
          state_nxt = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt <= '0;
    end else if (o_valid && !i_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign o_stall_cnt = stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (SKID=1 and SKID=0 builds).
`default_nettype none

module tb_pipe_stage_buf;

  localparam logic [127:0] BUB128 = 128'h13;
  localparam logic [31:0]  BUB32  = 32'h13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance, 2-bit stall counter
  logic         rst, valid, ready, flush;
  logic [127:0] data;
  logic         rdy, ov;
  logic [127:0] od;
  logic [1:0]   cnt;
  logic [1:0]   scnt;

  // SKID=0 instance
  logic         z_rst, z_valid, z_ready, z_flush;
  logic [31:0]  z_data;
  logic         z_rdy, z_ov;
  logic [31:0]  z_od;
  logic [1:0]   z_cnt;
  logic [15:0]  z_scnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_buf #(.WIDTH(128), .SKID(1), .STALL_CNT_W(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy), .i_data(data),
    .o_valid(ov), .i_ready(ready), .o_data(od), .i_flush(flush),
    .o_count(cnt), .o_stall_cnt(scnt)
  );

  pipe_stage_buf #(.WIDTH(32), .SKID(0)) u_dut0 (
    .i_clk(clk), .i_rst(z_rst), .i_valid(z_valid), .o_ready(z_rdy), .i_data(z_data),
    .o_valid(z_ov), .i_ready(z_ready), .o_data(z_od), .i_flush(z_flush),
    .o_count(z_cnt), .o_stall_cnt(z_scnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; ready = 1'b0; flush = 1'b0; data = '0;
    z_rst = 1'b1; z_valid = 1'b0; z_ready = 1'b0; z_flush = 1'b0; z_data = '0;
    tick();
    tick();
    rst = 1'b0; z_rst = 1'b0;

    // 1. reset defaults
    check("rst_valid", ov, 0);
    check("rst_data", od, BUB128);
    check("rst_count", cnt, 0);
    check("rst_stall", scnt, 0);
    check("rst_ready", rdy, 1);

    // 2. streaming
    ready = 1'b1; valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      data = 128'(i);
      tick();
      check($sformatf("stream_data%0d", i), od, 128'(i));
      check($sformatf("stream_valid%0d", i), ov, 1);
      check($sformatf("stream_count%0d", i), cnt, 1);
      check($sformatf("stream_ready%0d", i), rdy, 1);
    end
    valid = 1'b0;
    tick();
    check("drain_valid", ov, 0);
    check("drain_data", od, BUB128);
    check("drain_count", cnt, 0);

    // 3. backpressure
    ready = 1'b0; valid = 1'b1; data = 128'hA;
    tick();
    check("bp_a_data", od, 128'hA);
    check("bp_a_ready", rdy, 1);
    data = 128'hB;
    tick();
    check("bp_full_count", cnt, 2);
    check("bp_full_ready", rdy, 0);
    check("bp_full_data", od, 128'hA);
    data = 128'hC;
    tick();
    check("bp_hold_data", od, 128'hA);
    check("bp_hold_count", cnt, 2);
    valid = 1'b0; ready = 1'b1;
    tick();
    check("bp_pop_data", od, 128'hB);
    check("bp_pop_ready", rdy, 1);
    check("bp_pop_count", cnt, 1);
    tick();
    check("bp_empty_valid", ov, 0);
    check("bp_empty_data", od, BUB128);

    // 4. flush while FULL
    ready = 1'b0; valid = 1'b1; data = 128'hA;
    tick();
    data = 128'hB;
    tick();
    check("fl_pre_count", cnt, 2);
    flush = 1'b1; data = 128'hC;
    tick();
    flush = 1'b0; valid = 1'b0;
    check("fl_valid", ov, 0);
    check("fl_data", od, BUB128);
    check("fl_count", cnt, 0);
    check("fl_ready", rdy, 1);
    tick();
    check("fl_no_c_valid", ov, 0);
    check("fl_no_c_data", od, BUB128);

    // 5. stall counter saturation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sc_rst", scnt, 0);
    valid = 1'b1; ready = 1'b0; data = 128'h5;
    tick();
    valid = 1'b0;
    check("sc_first", scnt, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("sc_cycle%0d", i), scnt, (i > 3) ? 2'd3 : 2'(i));
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sc_flush_keep", scnt, 3);
    check("sc_flush_valid", ov, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sc_reset_clear", scnt, 0);

    // 6. SKID=0
    z_ready = 1'b0; z_valid = 1'b1; z_data = 32'h11;
    tick();
    check("z_load_data", z_od, 32'h11);
    check("z_load_count", z_cnt, 1);
    check("z_full_ready", z_rdy, 0);
    z_ready = 1'b1;
    #1;
    check("z_comb_ready", z_rdy, 1);
    z_data = 32'h22;
    tick();
    check("z_pushpop_data", z_od, 32'h22);
    check("z_pushpop_count", z_cnt, 1);
    check("z_stall", z_scnt, 0);
    z_valid = 1'b0;
    tick();
    check("z_pop_valid", z_ov, 0);
    check("z_pop_data", z_od, BUB32);
    check("z_pop_count", z_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised, elastic pipeline-stage register that generalises the fixed EX/MEM latch.
- Carries an opaque WIDTH-bit payload between any two pipeline stages.
- Adds a valid/ready handshake, an optional skid entry for full-throughput backpressure, flush with bubble injection, and a saturating stall-cycle counter.
- Placed between stages (IF/ID, ID/EX, EX/MEM, MEM/WB); the core's hazard unit drives i_flush.

Parameters:
- WIDTH, 128, payload width in bits (≥1).
- SKID, 1, 1 = two-entry buffer (main + skid) with registered o_ready; 0 = single entry with combinational o_ready.
- BUBBLE_VAL, {(WIDTH-32)'b0, 32'h00000013}, payload driven when the stage holds no valid entry (NOP in instruction field, all control bits 0).
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream offers i_data.
- o_ready  out  1  stage can accept; a transfer occurs when i_valid && o_ready.
- i_data  in  WIDTH  upstream payload.
- o_valid  out  1  o_data holds a valid entry.
- i_ready  in  1  downstream accepts; a transfer occurs when o_valid && i_ready.
- o_data  out  WIDTH  payload of the main entry, or BUBBLE_VAL when empty.
- i_flush  in  1  discard all entries at the next edge.
- o_count  out  2  occupancy: 0..1 (SKID=0) or 0..2 (SKID=1).
- o_stall_cnt  out  STALL_CNT_W  saturating count of cycles with o_valid && !i_ready.

Behaviour:
- Reset (i_rst=1 at edge): o_valid=0, o_data=BUBBLE_VAL, skid entry empty, o_count=0, o_stall_cnt=0. o_ready reads 1 in the first cycle after reset.
- Priority at each edge: reset > flush > normal operation.
- Latency: one cycle from an accepted input to o_valid, when the stage is empty.
- Data ordering: strictly FIFO; no payload is ever duplicated or dropped except on flush.

SKID=0:
- o_ready = !o_valid || i_ready (combinational).
- Accepted input loads the main entry.
- Pop without push: o_valid falls to 0 and o_data returns to BUBBLE_VAL.

SKID=1, states EMPTY(0), ONE(1), FULL(2):
- o_ready = !skid_valid, driven from a flop; no combinational path from i_ready.
- EMPTY + push → ONE; main = i_data.
- ONE + push + pop → ONE; main = i_data.
- ONE + pop only → EMPTY.
- ONE + push, no pop → FULL; skid = i_data; o_ready = 0 next cycle.
- FULL + pop → ONE; main = skid; o_ready = 1 next cycle.
- FULL never accepts input, because o_ready = 0.
- Sustained i_valid = i_ready = 1 gives one transfer per cycle.

Flush:
- Next cycle: o_valid = 0, o_data = BUBBLE_VAL, skid empty, o_count = 0.
- Input offered in the flush cycle is dropped, even if o_ready = 1.
- A downstream pop in the flush cycle still counts as a completed transfer for the downstream side.
- o_stall_cnt is not cleared by flush.

Stall counter:
- Increments when o_valid && !i_ready at an edge; saturates at all-ones; cleared only by reset.

Other:
- Flush asserted during reset has no extra effect.
- i_data is ignored when i_valid = 0.
- o_data changes only on an edge.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INSTR = 32'h00000013
  - default bubble constant
  - occupancy encoding localparams EMPTY/ONE/FULL
- Sub-module pipe_entry: WIDTH-bit register with load enable, synchronous reset to RST_VAL, and a valid bit. Instantiated twice: main and skid.
- Top level holds the control FSM and the stall counter.

Test Plan:
1. Reset, defaults (WIDTH=128, SKID=1): i_rst=1 for 2 cycles → o_valid=0, o_data[31:0]=32'h00000013, o_count=0, o_stall_cnt=0; o_ready=1 after reset.
2. Streaming: push 0x1, 0x2, 0x3 on consecutive cycles with i_ready=1 → o_data 0x1, 0x2, 0x3 on cycles 1, 2, 3; o_ready stays 1; o_count=1 throughout.
3. Backpressure: i_ready=0, push 0xA then 0xB → o_count=2, o_ready=0, o_data=0xA. Raise i_ready → next cycle o_data=0xB, o_ready=1; no loss or duplication.
4. Flush when FULL: contents 0xA/0xB, assert i_flush with i_valid=1 and i_data=0xC → next cycle o_valid=0, o_data=BUBBLE_VAL, o_count=0; 0xC never appears.
5. Stall counter (STALL_CNT_W=2): hold o_valid=1, i_ready=0 for 5 cycles → o_stall_cnt goes 1, 2, 3, 3, 3. Flush → counter stays 3. Reset → 0.
6. SKID=0: i_ready=0 while full → o_ready=0 in the same cycle. Push and pop in one cycle → o_data = new value next cycle, o_count stays 1.
